// File: rtl/bster_pkg.sv
// Shared types and sizing helpers for the BST node datapath.
// Node layout is {parent,right,left,payload,token} with token at the LSB.
package bster_pkg;

    localparam int DEF_TOKEN_W   = 8;
    localparam int DEF_PAYLOAD_W = 32;
    localparam int DEF_PTR_W     = 8;
    localparam int DEF_DATA_W    = 32;

    function automatic int calc_node_w(input int token_w, input int payload_w, input int ptr_w);
        return token_w + payload_w + 3 * ptr_w;
    endfunction

    function automatic int calc_nb(input int node_w, input int data_w);
        return (node_w + data_w - 1) / data_w;
    endfunction

    function automatic int calc_stride(input int nb, input int data_w);
        return nb * data_w / 8;
    endfunction

    localparam int NODE_W = calc_node_w(DEF_TOKEN_W, DEF_PAYLOAD_W, DEF_PTR_W);
    localparam int NB     = calc_nb(NODE_W, DEF_DATA_W);
    localparam int STRIDE = calc_stride(NB, DEF_DATA_W);

    typedef struct packed {
        logic [DEF_PTR_W-1:0]     parent;
        logic [DEF_PTR_W-1:0]     right;
        logic [DEF_PTR_W-1:0]     left;
        logic [DEF_PAYLOAD_W-1:0] payload;
        logic [DEF_TOKEN_W-1:0]   token;
    } node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CPL  = 2'd3
    } fsm_e;

    function automatic logic [NODE_W-1:0] pack_node(input node_t n);
        return n;
    endfunction

    function automatic node_t unpack_node(input logic [NODE_W-1:0] v);
        return node_t'(v);
    endfunction

endpackage

// File: rtl/bst_node_buffer.sv
// NB-word node register: whole-node parallel load, or single-word capture at an index.
// Latency: one cycle from load/capture strobe to buf_o; no backpressure (load wins over capture).
// Backpressure: none, the owner sequences load/capture strobes.
module bst_node_buffer #(
    parameter int WORD_W = 32,
    parameter int NB     = 2,
    parameter int IDX_W  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [NB*WORD_W-1:0] load_dat_i,
    input  logic                 cap_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [WORD_W-1:0]    cap_dat_i,
    output logic [NB*WORD_W-1:0] buf_o
);

    logic [NB*WORD_W-1:0] buf_q;
    logic [NB*WORD_W-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        if (load_i) begin
            buf_d = load_dat_i;
        end else if (cap_i) begin
            for (int b = 0; b < NB; b++) begin
                if (idx_i == IDX_W'(b)) begin
                    buf_d[b*WORD_W +: WORD_W] = cap_dat_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign buf_o = buf_q;

endmodule

// File: rtl/bst_node_accessor.sv
// Node front end: splits whole-node reads/writes into NB word beats and reassembles read nodes.
// Latency: write done accept+NB cycles; read completion the cycle after the last word is captured.
// Backpressure: one request in flight, req_ready low outside IDLE; mem_ready/cpl_ready stalls hold outputs.
module bst_node_accessor
    import bster_pkg::*;
#(
    parameter int          TOKEN_WIDTH    = 8,
    parameter int          PAYLOAD_WIDTH  = 32,
    parameter int          PTR_WIDTH      = 8,
    parameter int          RAM_DATA_WIDTH = 32,
    parameter int          RAM_ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wr,
    input  logic [PTR_WIDTH-1:0]      req_ptr,
    input  logic [calc_node_w(TOKEN_WIDTH, PAYLOAD_WIDTH, PTR_WIDTH)-1:0] req_node,
    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [calc_node_w(TOKEN_WIDTH, PAYLOAD_WIDTH, PTR_WIDTH)-1:0] cpl_node,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
    input  logic                      mem_rd_valid,
    output logic                      mem_rd_ready,
    input  logic [RAM_DATA_WIDTH-1:0] mem_rd_data
);

    localparam int NODE_BITS = calc_node_w(TOKEN_WIDTH, PAYLOAD_WIDTH, PTR_WIDTH);
    localparam int BEATS     = calc_nb(NODE_BITS, RAM_DATA_WIDTH);
    localparam int STRIDE_B  = calc_stride(BEATS, RAM_DATA_WIDTH);
    localparam int BUF_W     = BEATS * RAM_DATA_WIDTH;
    localparam int CNT_W     = $clog2(BEATS + 1);

    localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]          NUM_BEATS = CNT_W'(BEATS);
    localparam logic [RAM_ADDR_WIDTH-1:0] BASE_A    = RAM_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [RAM_ADDR_WIDTH-1:0] STRIDE_A  = RAM_ADDR_WIDTH'(STRIDE_B);
    localparam logic [RAM_ADDR_WIDTH-1:0] WORD_A    = RAM_ADDR_WIDTH'(RAM_DATA_WIDTH / 8);

    fsm_e                 state_q, state_d;
    logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]     rcv_cnt_q, rcv_cnt_d;
    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic                 up_q;

    logic                      buf_load;
    logic                      buf_cap;
    logic [BUF_W-1:0]          load_dat;
    logic [BUF_W-1:0]          node_buf;
    logic [RAM_DATA_WIDTH-1:0] wr_word;
    logic [RAM_ADDR_WIDTH-1:0] addr_calc;

    // Same buffer holds the outgoing node for writes and the reassembled node for reads.
    bst_node_buffer #(
        .WORD_W (RAM_DATA_WIDTH),
        .NB     (BEATS),
        .IDX_W  (CNT_W)
    ) u_buf (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .load_i     (buf_load),
        .load_dat_i (load_dat),
        .cap_i      (buf_cap),
        .idx_i      (rcv_cnt_q),
        .cap_dat_i  (mem_rd_data),
        .buf_o      (node_buf)
    );

    always_comb begin
        load_dat                = '0;
        load_dat[NODE_BITS-1:0] = req_node;
    end

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        ptr_d        = ptr_q;
        req_ready    = 1'b0;
        cpl_valid    = 1'b0;
        mem_valid    = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_rd_ready = 1'b0;
        buf_load     = 1'b0;
        buf_cap      = 1'b0;
        case (state_q)
            IDLE: begin
                // up_q keeps req_ready low until the first cycle after reset release.
                req_ready = up_q;
                if (req_valid && up_q) begin
                    ptr_d       = req_ptr;
                    buf_load    = 1'b1;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                    state_d     = req_wr ? WR : RD;
                end
            end
            WR: begin
                mem_valid = 1'b1;
                mem_wr    = 1'b1;
                if (mem_ready) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            RD: begin
                mem_rd_ready = 1'b1;
                if (issue_cnt_q < NUM_BEATS) begin
                    mem_valid = 1'b1;
                    mem_rd    = 1'b1;
                    if (mem_ready) begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end
                end
                if (mem_rd_valid) begin
                    buf_cap   = 1'b1;
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                    if (rcv_cnt_q == LAST_BEAT) begin
                        state_d = CPL;
                    end
                end
            end
            CPL: begin
                cpl_valid = 1'b1;
                if (cpl_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_word = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (issue_cnt_q == CNT_W'(b)) begin
                wr_word = node_buf[b*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
            end
        end
    end

    // Address arithmetic is done at RAM_ADDR_WIDTH so overflow wraps silently.
    assign addr_calc = BASE_A + RAM_ADDR_WIDTH'(ptr_q) * STRIDE_A
                     + RAM_ADDR_WIDTH'(issue_cnt_q) * WORD_A;

    assign mem_addr    = mem_valid ? addr_calc : '0;
    assign mem_wr_data = mem_wr ? wr_word : '0;
    assign cpl_node    = cpl_valid ? node_buf[NODE_BITS-1:0] : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            ptr_q       <= '0;
            up_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            ptr_q       <= ptr_d;
            up_q        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bst_node_accessor.sv
// Directed plus random bench for bst_node_accessor with a word RAM model and node/beat scoreboards.
module tb_bst_node_accessor;
    import bster_pkg::*;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
    } beat_t;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              req_valid, req_ready, req_wr;
    logic [7:0]        req_ptr;
    logic [NODE_W-1:0] req_node;
    logic              cpl_valid, cpl_ready;
    logic [NODE_W-1:0] cpl_node;
    logic              mem_valid, mem_ready, mem_rd, mem_wr;
    logic [15:0]       mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_rd_valid, mem_rd_ready;
    logic [31:0]       mem_rd_data;

    logic              w_req_valid, w_req_ready, w_req_wr;
    logic [7:0]        w_req_ptr;
    logic [NODE_W-1:0] w_req_node;
    logic              w_cpl_valid, w_cpl_ready;
    logic [NODE_W-1:0] w_cpl_node;
    logic              w_mem_valid, w_mem_ready, w_mem_rd, w_mem_wr;
    logic [15:0]       w_mem_addr;
    logic [31:0]       w_mem_wr_data;
    logic              w_mem_rd_valid, w_mem_rd_ready;
    logic [31:0]       w_mem_rd_data;

    logic [31:0]       mem [0:16383];
    logic [NODE_W-1:0] ref_node [0:255];
    beat_t             exp_beats[$];
    beat_t             blog[$];
    logic [NODE_W-1:0] exp_cpl[$];
    logic [31:0]       rsp_q[$];
    logic [15:0]       w_addr_log[$];
    logic [NODE_W-1:0] last_cpl;
    int                n_chk = 0;
    int                n_err = 0;
    int                n_cpl = 0;
    int                n_wr_hs = 0;

    always #5 aclk = ~aclk;

    bst_node_accessor u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_ptr(req_ptr), .req_node(req_node),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_node(cpl_node),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data)
    );

    bst_node_accessor #(.BASE_ADDR(32'hFFF8)) u_wrap (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_wr(w_req_wr),
        .req_ptr(w_req_ptr), .req_node(w_req_node),
        .cpl_valid(w_cpl_valid), .cpl_ready(w_cpl_ready), .cpl_node(w_cpl_node),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_rd(w_mem_rd), .mem_wr(w_mem_wr),
        .mem_addr(w_mem_addr), .mem_wr_data(w_mem_wr_data),
        .mem_rd_valid(w_mem_rd_valid), .mem_rd_ready(w_mem_rd_ready), .mem_rd_data(w_mem_rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {58'd0, req_ready, cpl_valid, mem_valid, mem_rd, mem_wr, mem_rd_ready}, 64'd0);
        chk({tag, "_addr"}, mem_addr, 64'd0);
        chk({tag, "_wdata"}, mem_wr_data, 64'd0);
        chk({tag, "_cpl_node"}, cpl_node, 64'd0);
    endtask

    // One clock: present read returns, score handshakes of this cycle, advance to #1 after the edge.
    task automatic tick();
        beat_t e;
        bit    hs_req, hs_mem, hs_rd, hs_cpl, w_hs;
        if (rsp_q.size() != 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = rsp_q[0];
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
        end
        hs_req = req_valid && req_ready;
        hs_mem = mem_valid && mem_ready;
        hs_rd  = mem_rd_valid && mem_rd_ready;
        hs_cpl = cpl_valid && cpl_ready;
        w_hs   = w_req_valid && w_req_ready;
        if (hs_req) begin
            for (int b = 0; b < 2; b++) begin
                e.wr   = req_wr;
                e.addr = 16'(req_ptr) * 16'd8 + 16'(b * 4);
                e.data = req_wr ? req_node[b*32 +: 32] : 32'h0;
                exp_beats.push_back(e);
            end
            if (req_wr) ref_node[req_ptr] = req_node;
            else        exp_cpl.push_back(ref_node[req_ptr]);
        end
        if (hs_rd) void'(rsp_q.pop_front());
        if (hs_mem) begin
            blog.push_back('{wr: mem_wr, addr: mem_addr, data: mem_wr_data});
            chk("mem_beat_expected", 64'(exp_beats.size() != 0), 64'd1);
            if (exp_beats.size() != 0) begin
                e = exp_beats.pop_front();
                chk("mem_wr", mem_wr, e.wr);
                chk("mem_rd", mem_rd, !e.wr);
                chk("mem_addr", mem_addr, e.addr);
                if (e.wr) chk("mem_wr_data", mem_wr_data, e.data);
            end
            if (mem_wr) begin
                mem[mem_addr[15:2]] = mem_wr_data;
                n_wr_hs++;
            end
            if (mem_rd) rsp_q.push_back(mem[mem_addr[15:2]]);
        end
        if (hs_cpl) begin
            n_cpl++;
            last_cpl = cpl_node;
            chk("cpl_expected", 64'(exp_cpl.size() != 0), 64'd1);
            if (exp_cpl.size() != 0) chk("cpl_node", cpl_node, exp_cpl.pop_front());
        end
        if (w_mem_valid && w_mem_ready) w_addr_log.push_back(w_mem_addr);
        @(posedge aclk);
        #1;
        if (w_hs) w_req_valid = 1'b0;
    endtask

    task automatic issue(input bit wr, input logic [7:0] ptr, input logic [63:0] node, input bit rnd);
        int budget = 0;
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_ptr   = ptr;
        req_node  = node;
        while (!acc && budget < 200) begin
            if (rnd) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                cpl_ready = ($urandom_range(0, 3) != 0);
            end
            acc = req_ready;
            tick();
            budget++;
        end
        req_valid = 1'b0;
        chk("req_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input bit rnd, output int lat);
        lat = 0;
        while ((exp_beats.size() != 0 || exp_cpl.size() != 0 || !req_ready) && lat < 400) begin
            if (rnd) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                cpl_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
            lat++;
        end
        chk("req_done_in_budget", 64'(lat < 400), 64'd1);
        mem_ready = 1'b1;
        cpl_ready = 1'b1;
    endtask

    initial begin
        int          lat, c0, budget;
        logic [63:0] n1, na, nb_, nr;
        node_t       nt;
        aresetn = 1'b0;
        req_valid = 0; req_wr = 0; req_ptr = 0; req_node = 0;
        cpl_ready = 1; mem_ready = 1; mem_rd_valid = 0; mem_rd_data = 0;
        w_req_valid = 0; w_req_wr = 0; w_req_ptr = 0; w_req_node = 0;
        w_cpl_ready = 1; w_mem_ready = 1; w_mem_rd_valid = 0; w_mem_rd_data = 0;
        last_cpl = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) ref_node[i] = '0;

        // Reset state and req_ready rising after release
        repeat (3) @(posedge aclk);
        #1;
        chk_zero("rst");
        aresetn = 1'b1;
        chk("req_ready_at_release", req_ready, 1'b0);
        tick();
        chk("req_ready_after_release", req_ready, 1'b1);

        // Test 1: write ptr=3
        nt = '{parent: 8'h01, right: 8'h02, left: 8'h03, payload: 32'h04556677, token: 8'h88};
        n1 = pack_node(nt);
        blog.delete();
        issue(1'b1, 8'd3, n1, 1'b0);
        drain(1'b0, lat);
        chk("t1_latency", lat, 2);
        chk("t1_beats", blog.size(), 2);
        if (blog.size() == 2) begin
            chk("t1_b0_addr", blog[0].addr, 16'h0018);
            chk("t1_b0_data", blog[0].data, 32'h55667788);
            chk("t1_b1_addr", blog[1].addr, 16'h001C);
            chk("t1_b1_data", blog[1].data, 32'h01020304);
        end

        // Test 2: read back ptr=3
        blog.delete();
        c0 = n_cpl;
        issue(1'b0, 8'd3, '0, 1'b0);
        drain(1'b0, lat);
        repeat (5) tick();
        chk("t2_beats", blog.size(), 2);
        if (blog.size() == 2) begin
            chk("t2_b0", {blog[0].wr, blog[0].addr}, {1'b0, 16'h0018});
            chk("t2_b1", {blog[1].wr, blog[1].addr}, {1'b0, 16'h001C});
        end
        chk("t2_cpl_once", n_cpl - c0, 1);
        chk("t2_node", last_cpl, 64'h0102030455667788);
        nt = unpack_node(last_cpl);
        chk("t2_payload", nt.payload, 32'h04556677);

        // Test 3: mem_ready low 5 cycles during write beat 1
        c0 = n_wr_hs;
        nr = {$urandom, $urandom};
        issue(1'b1, 8'd5, nr, 1'b0);
        tick();
        mem_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("t3_valid", {mem_valid, mem_wr, mem_rd}, 3'b110);
            chk("t3_addr", mem_addr, 16'h002C);
            chk("t3_data", mem_wr_data, nr[63:32]);
        end
        mem_ready = 1'b1;
        tick();
        chk("t3_wr_hs", n_wr_hs - c0, 2);
        chk("t3_idle", req_ready, 1'b1);

        // Test 4: cpl_ready low for 10 cycles, next request waits
        cpl_ready = 1'b0;
        c0 = n_cpl;
        issue(1'b0, 8'd5, '0, 1'b0);
        req_valid = 1'b1; req_wr = 1'b1; req_ptr = 8'd7; req_node = {$urandom, $urandom};
        budget = 0;
        while (!cpl_valid && budget < 20) begin
            tick();
            budget++;
        end
        chk("t4_cpl_seen", cpl_valid, 1'b1);
        repeat (10) begin
            chk("t4_cpl_hold", {cpl_valid, req_ready}, 2'b10);
            chk("t4_node_hold", cpl_node, nr);
            tick();
        end
        cpl_ready = 1'b1;
        tick();
        chk("t4_cpl_once", n_cpl - c0, 1);
        chk("t4_ready_after", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("t4_next_accepted", 64'(exp_beats.size()), 2);
        drain(1'b0, lat);

        // Test 5: async reset between read beat 0 and beat 1
        na  = {$urandom, $urandom};
        nb_ = {$urandom, $urandom};
        issue(1'b1, 8'd9, na, 1'b0);
        drain(1'b0, lat);
        issue(1'b1, 8'd0, nb_, 1'b0);
        drain(1'b0, lat);
        issue(1'b0, 8'd9, '0, 1'b0);
        tick();
        aresetn = 1'b0;
        #1;
        chk_zero("t5_rst");
        exp_beats.delete();
        exp_cpl.delete();
        rsp_q.delete();
        tick();
        aresetn = 1'b1;
        chk("t5_ready_release", req_ready, 1'b0);
        tick();
        chk("t5_ready_up", req_ready, 1'b1);
        issue(1'b0, 8'd0, '0, 1'b0);
        drain(1'b0, lat);
        chk("t5_fresh_node", last_cpl, nb_);

        // Test 6: address wrap with BASE=0xFFF8
        w_addr_log.delete();
        w_req_valid = 1'b1; w_req_wr = 1'b1; w_req_ptr = 8'd255; w_req_node = {$urandom, $urandom};
        budget = 0;
        while (w_addr_log.size() < 2 && budget < 20) begin
            tick();
            budget++;
        end
        chk("t6_beats", w_addr_log.size(), 2);
        if (w_addr_log.size() == 2) begin
            chk("t6_addr0", w_addr_log[0], 16'h07F0);
            chk("t6_addr1", w_addr_log[1], 16'h07F4);
        end

        // Random mix against the scoreboard
        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b1);
            drain(1'b1, lat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
